// File: rtl/fp_pkg.sv
// Shared float32 field layout, requester index type and default tag width
// for the fp_add_sched slice.
package fp_pkg;

  localparam int unsigned TAG_W_DEF = 4;

  typedef logic req_idx_t;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned FRAC_MSB = 22;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

  function automatic logic [31:0] flip_sign(input logic [31:0] x, input logic en);
    flip_sign           = x;
    flip_sign[SIGN_BIT] = x[SIGN_BIT] ^ en;
  endfunction

endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder: round-to-nearest-even,
// subnormal inputs/outputs, exact cancellation yields +0.
module fp_adder
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);

  logic        a_big;
  logic [31:0] big, sml;
  logic [7:0]  eb_f, es_f;
  logic [9:0]  e_big, e_sml, d, nsh, e, exp_f;
  logic [4:0]  dcap, lz;
  logic [23:0] m_big, m_sml;
  logic [49:0] al;
  logic [26:0] op_big, op_sml, m;
  logic [27:0] sum;
  logic        sub_op, rnd, big_nan, sml_nan, any_special;
  logic [24:0] mant_r;
  logic [22:0] frac_f;

  assign a_big = a[30:0] >= b[30:0];
  assign big   = a_big ? a : b;
  assign sml   = a_big ? b : a;

  always_comb begin
    eb_f   = big[EXP_MSB:EXP_LSB];
    es_f   = sml[EXP_MSB:EXP_LSB];
    e_big  = (eb_f == 8'd0) ? 10'd1 : {2'b00, eb_f};
    e_sml  = (es_f == 8'd0) ? 10'd1 : {2'b00, es_f};
    m_big  = {eb_f != 8'd0, big[FRAC_MSB:0]};
    m_sml  = {es_f != 8'd0, sml[FRAC_MSB:0]};
    d      = e_big - e_sml;
    dcap   = (d > 10'd31) ? 5'd31 : d[4:0];
    // Operands carry guard, round and sticky below the 24-bit significand.
    al     = {m_sml, 26'b0} >> dcap;
    op_sml = {al[49:24], |al[23:0]};
    op_big = {m_big, 3'b000};
    sub_op = big[SIGN_BIT] ^ sml[SIGN_BIT];
    sum    = sub_op ? ({1'b0, op_big} - {1'b0, op_sml})
                    : ({1'b0, op_big} + {1'b0, op_sml});

    lz = 5'd27;
    for (int unsigned i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end
    // Left shift is capped so the exponent never drops below 1 (subnormal floor).
    nsh = ({5'b0, lz} < (e_big - 10'd1)) ? {5'b0, lz} : (e_big - 10'd1);

    if (sum[27]) begin
      m = {sum[27:2], sum[1] | sum[0]};
      e = e_big + 10'd1;
    end else begin
      m = sum[26:0] << nsh;
      e = e_big - nsh;
    end

    rnd    = m[2] & (m[1] | m[0] | m[3]);
    mant_r = {1'b0, m[26:3]} + {24'b0, rnd};
    exp_f  = mant_r[24] ? (e + 10'd1) : (mant_r[23] ? e : 10'd0);
    frac_f = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    big_nan     = (eb_f == EXP_MAX) && (big[FRAC_MSB:0] != '0);
    sml_nan     = (es_f == EXP_MAX) && (sml[FRAC_MSB:0] != '0);
    any_special = (eb_f == EXP_MAX) || (es_f == EXP_MAX);

    if (any_special) begin
      if (big_nan || sml_nan || ((es_f == EXP_MAX) && sub_op)) s = 32'h7FC0_0000;
      else                                                      s = {big[SIGN_BIT], EXP_MAX, 23'b0};
    end else if (sum == '0) begin
      s = {big[SIGN_BIT] & sml[SIGN_BIT], 31'b0};
    end else if (exp_f >= 10'd255) begin
      s = {big[SIGN_BIT], EXP_MAX, 23'b0};
    end else begin
      s = {big[SIGN_BIT], exp_f[7:0], frac_f};
    end
  end

endmodule

// File: rtl/fp_add_sched.sv
// Two-requester round-robin scheduler feeding a 2-stage float32 add pipeline.
// Optional macro FP_ADD_SCHED_SUB_EN adds r0_sub/r1_sub ports (result a-b).
module fp_add_sched
  import fp_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [31:0]      r0_a,
  input  logic [31:0]      r0_b,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [31:0]      r1_a,
  input  logic [31:0]      r1_b,
  input  logic [TAG_W-1:0] r1_tag,
`ifdef FP_ADD_SCHED_SUB_EN
  input  logic             r0_sub,
  input  logic             r1_sub,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_s,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag
);

  logic             s1_valid, s2_valid;
  logic [31:0]      s1_a, s1_b, s2_s, sum;
  req_idx_t         s1_src, s2_src, prio;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic             s2_adv, s1_free, acc0, acc1, r0_neg, r1_neg;

`ifdef FP_ADD_SCHED_SUB_EN
  assign r0_neg = r0_sub;
  assign r1_neg = r1_sub;
`else
  assign r0_neg = 1'b0;
  assign r1_neg = 1'b0;
`endif

  assign s2_adv  = !s2_valid | res_ready;
  assign s1_free = !s1_valid | s2_adv;
  // Readies are held low while rst is high so nothing is granted during reset.
  assign r0_ready = !rst & s1_free & ((prio == 1'b0) | !r1_valid);
  assign r1_ready = !rst & s1_free & ((prio == 1'b1) | !r0_valid);
  assign acc0     = r0_valid & r0_ready;
  assign acc1     = r1_valid & r1_ready;

  fp_adder u_adder (
    .a (s1_a),
    .b (s1_b),
    .s (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      prio     <= 1'b0;
      s2_s     <= '0;
      s2_src   <= 1'b0;
      s2_tag   <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_s   <= sum;
          s2_src <= s1_src;
          s2_tag <= s1_tag;
        end
      end
      if (s1_free) s1_valid <= acc0 | acc1;
      if (acc0) begin
        s1_a   <= r0_a;
        s1_b   <= flip_sign(r0_b, r0_neg);
        s1_src <= 1'b0;
        s1_tag <= r0_tag;
        prio   <= 1'b1;
      end else if (acc1) begin
        s1_a   <= r1_a;
        s1_b   <= flip_sign(r1_b, r1_neg);
        s1_src <= 1'b1;
        s1_tag <= r1_tag;
        prio   <= 1'b0;
      end
    end
  end

  assign res_valid = s2_valid;
  assign res_s     = s2_s;
  assign res_src   = s2_src;
  assign res_tag   = s2_tag;

endmodule

// File: tb/tb_fp_add_sched.sv
// Directed self-checking bench for fp_add_sched (FP_ADD_SCHED_SUB_EN adds the subtract case).
module tb_fp_add_sched;

  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0]   r0_a, r0_b, r1_a, r1_b;
  logic [TW-1:0] r0_tag, r1_tag;
`ifdef FP_ADD_SCHED_SUB_EN
  logic          r0_sub, r1_sub;
`endif
  logic          res_valid, res_ready, res_src;
  logic [31:0]   res_s;
  logic [TW-1:0] res_tag;

  int checks = 0;
  int errors = 0;

  fp_add_sched #(.TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_tag(r1_tag),
`ifdef FP_ADD_SCHED_SUB_EN
    .r0_sub(r0_sub), .r1_sub(r1_sub),
`endif
    .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s),
    .res_src(res_src), .res_tag(res_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r0_valid = 0; r1_valid = 0;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    r0_tag = '0; r1_tag = '0;
`ifdef FP_ADD_SCHED_SUB_EN
    r0_sub = 0; r1_sub = 0;
`endif
  endtask

  task automatic do_reset();
    idle();
    rst = 1; res_ready = 1;
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; res_ready = 1;
    step();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b expected 0", res_valid); end
    checks++; if (res_s !== 32'h0) begin errors++; $display("FAIL rst_res_s: got %h expected 00000000", res_s); end
    checks++; if (res_src !== 1'b0) begin errors++; $display("FAIL rst_res_src: got %b expected 0", res_src); end
    checks++; if (res_tag !== 4'h0) begin errors++; $display("FAIL rst_res_tag: got %h expected 0", res_tag); end
    checks++; if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", {r0_ready, r1_ready}); end
    step();
    rst = 0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL post_rst_res_valid: got %b expected 0", res_valid); end
  endtask

  task automatic test_single();
    do_reset();
    r0_valid = 1; r0_a = 32'h3F80_0000; r0_b = 32'h4000_0000; r0_tag = 4'd3;
    @(negedge clk);
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", r0_ready); end
    step();
    r0_valid = 0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", res_valid); end
    step();
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", res_valid); end
    checks++; if (res_s !== 32'h4040_0000) begin errors++; $display("FAIL single_s: got %h expected 40400000", res_s); end
    checks++; if (res_src !== 1'b0) begin errors++; $display("FAIL single_src: got %b expected 0", res_src); end
    checks++; if (res_tag !== 4'd3) begin errors++; $display("FAIL single_tag: got %h expected 3", res_tag); end
    step();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", res_valid); end
  endtask

  task automatic test_alternate();
    logic          e_src;
    logic [31:0]   e_s;
    logic [TW-1:0] e_tag;
    do_reset();
    r0_valid = 1; r0_a = 32'h3F80_0000; r0_b = 32'h3F80_0000; r0_tag = 4'd1;
    r1_valid = 1; r1_a = 32'h4000_0000; r1_b = 32'h4000_0000; r1_tag = 4'd2;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({r0_ready, r1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL alt_grant[%0d]: got %b expected %b", k, {r0_ready, r1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (k >= 2) begin
        e_src = ((k - 2) % 2 == 1);
        e_s   = e_src ? 32'h4080_0000 : 32'h4000_0000;
        e_tag = e_src ? 4'd2 : 4'd1;
        checks++;
        if (res_valid !== 1'b1 || res_src !== e_src || res_tag !== e_tag || res_s !== e_s) begin
          errors++; $display("FAIL alt_result[%0d]: got v=%b src=%b tag=%h s=%h expected v=1 src=%b tag=%h s=%h",
                             k, res_valid, res_src, res_tag, res_s, e_src, e_tag, e_s);
        end
      end
      step();
    end
    idle();
    step(); step(); step();
  endtask

  task automatic test_backpressure();
    int accepts;
    accepts = 0;
    do_reset();
    res_ready = 0;
    r0_valid = 1; r0_a = 32'h3F80_0000; r0_b = 32'h3F80_0000; r0_tag = 4'd1;
    r1_valid = 1; r1_a = 32'h4000_0000; r1_b = 32'h4000_0000; r1_tag = 4'd2;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (r0_valid && r0_ready) accepts++;
      if (r1_valid && r1_ready) accepts++;
      if (k >= 2) begin
        checks++;
        if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 00", k, {r0_ready, r1_ready}); end
        checks++;
        if (res_valid !== 1'b1 || res_s !== 32'h4000_0000 || res_src !== 1'b0 || res_tag !== 4'd1) begin
          errors++; $display("FAIL bp_hold[%0d]: got v=%b s=%h src=%b tag=%h expected v=1 s=40000000 src=0 tag=1",
                             k, res_valid, res_s, res_src, res_tag);
        end
      end
      step();
    end
    checks++; if (accepts != 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", accepts); end
    res_ready = 1; r0_tag = 4'd5;
    @(negedge clk);
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL bp_release_accept: got %b expected 1", r0_ready); end
    checks++;
    if (res_valid !== 1'b1 || res_src !== 1'b0 || res_tag !== 4'd1) begin
      errors++; $display("FAIL bp_out0: got v=%b src=%b tag=%h expected v=1 src=0 tag=1", res_valid, res_src, res_tag);
    end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_src !== 1'b1 || res_tag !== 4'd2 || res_s !== 32'h4080_0000) begin
      errors++; $display("FAIL bp_out1: got v=%b src=%b tag=%h s=%h expected v=1 src=1 tag=2 s=40800000", res_valid, res_src, res_tag, res_s);
    end
    step();
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_src !== 1'b0 || res_tag !== 4'd5 || res_s !== 32'h4000_0000) begin
      errors++; $display("FAIL bp_out2: got v=%b src=%b tag=%h s=%h expected v=1 src=0 tag=5 s=40000000", res_valid, res_src, res_tag, res_s);
    end
    step();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", res_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] va [8] = '{32'h4040_0000, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000,
                            32'h3F80_0001, 32'h7F7F_FFFF, 32'h0080_0000, 32'h3FC0_0000};
    logic [31:0] vb [8] = '{32'hC040_0000, 32'h0000_0001, 32'h4000_0000, 32'h3380_0000,
                            32'h3380_0000, 32'h7F7F_FFFF, 32'h8000_0001, 32'hBE80_0000};
    logic [31:0] vs [8] = '{32'h0000_0000, 32'h0000_0002, 32'h4040_0000, 32'h3F80_0000,
                            32'h3F80_0002, 32'h7F80_0000, 32'h007F_FFFF, 32'h3FA0_0000};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        r0_valid = 1; r0_a = va[k]; r0_b = vb[k]; r0_tag = 4'(k);
      end else begin
        r0_valid = 0;
      end
      @(negedge clk);
      if (k < 8) begin
        checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", k, r0_ready); end
      end
      if (k >= 2) begin
        checks++;
        if (res_valid !== 1'b1 || res_s !== vs[k-2] || res_tag !== 4'(k - 2)) begin
          errors++; $display("FAIL stream_sum[%0d]: got v=%b s=%h tag=%h expected v=1 s=%h tag=%h",
                             k - 2, res_valid, res_s, res_tag, vs[k-2], 4'(k - 2));
        end
      end
      step();
    end
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b expected 0", res_valid); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    res_ready = 0;
    r0_valid = 1; r0_a = 32'h3F80_0000; r0_b = 32'h3F80_0000; r0_tag = 4'd9;
    step(); step();
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || r0_ready !== 1'b0) begin
      errors++; $display("FAIL mid_full: got v=%b r0_ready=%b expected v=1 r0_ready=0", res_valid, r0_ready);
    end
    rst = 1; r0_valid = 0;
    step();
    rst = 0; res_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got %b expected 0", k, res_valid); end
      step();
    end
    r0_valid = 1; r0_tag = 4'd4;
    r1_valid = 1; r1_a = 32'h4000_0000; r1_b = 32'h4000_0000; r1_tag = 4'd6;
    @(negedge clk);
    checks++;
    if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL mid_prio: got %b expected 10", {r0_ready, r1_ready}); end
    step();
    idle();
    step();
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_src !== 1'b0 || res_tag !== 4'd4) begin
      errors++; $display("FAIL mid_first: got v=%b src=%b tag=%h expected v=1 src=0 tag=4", res_valid, res_src, res_tag);
    end
    step();
  endtask

`ifdef FP_ADD_SCHED_SUB_EN
  task automatic test_sub();
    do_reset();
    r1_valid = 1; r1_a = 32'h4040_0000; r1_b = 32'h3F80_0000; r1_sub = 1; r1_tag = 4'd7;
    step();
    idle();
    step();
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_s !== 32'h4000_0000 || res_src !== 1'b1 || res_tag !== 4'd7) begin
      errors++; $display("FAIL sub_result: got v=%b s=%h src=%b tag=%h expected v=1 s=40000000 src=1 tag=7",
                         res_valid, res_s, res_src, res_tag);
    end
    step();
  endtask
`endif

  initial begin
    idle();
    rst = 1; res_ready = 1;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_stream();
    test_reset_midflight();
`ifdef FP_ADD_SCHED_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
